t_ff: RTL and testbench

T_FF -- requirements
Module: t_ff

---
 rtl/t_ff.sv | 61 ++++++
 tb/tb_t_ff.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/t_ff.sv
// rtl/t_ff.sv - WIDTH independent toggle flip-flops with synchronous active-low reset
// Each bit is a d flip-flop fed with t_in ^ q; reset wins over toggle.

module t_ff_dff (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic state_d;
  logic state_q;

  always_comb begin
    state_d = d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= rst_val;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule

module t_ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic [WIDTH-1:0] t_in,
  input  logic             rst,
  input  logic             clk,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  logic [WIDTH-1:0] toggle_d;

  always_comb begin
    toggle_d = t_in ^ q;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_ff_dff u_dff (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RST_VAL[i]),
      .d       (toggle_d[i]),
      .q       (q[i])
    );
  end

  // q_bar comes from the registered q only, so it tracks q through reset too
  assign q_bar = ~q;

endmodule

// File: tb/tb_t_ff.sv
// tb/tb_t_ff.sv - directed self-checking bench for t_ff (scalar and 4-bit instances)

module tb_t_ff;

  logic       clk;
  logic       rst;
  logic       t_in;
  logic       q;
  logic       q_bar;

  logic       v_rst;
  logic [3:0] v_t;
  logic [3:0] v_q;
  logic [3:0] v_q_bar;

  int checks;
  int errors;

  t_ff u_dut (
    .t_in  (t_in),
    .rst   (rst),
    .clk   (clk),
    .q     (q),
    .q_bar (q_bar)
  );

  t_ff #(.WIDTH(4), .RST_VAL(4'b1010)) u_vec (
    .t_in  (v_t),
    .rst   (v_rst),
    .clk   (clk),
    .q     (v_q),
    .q_bar (v_q_bar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    t_in = 1'b0;
    step();
    checks++;
    if (q !== 1'b0) begin
      errors++;
      $display("FAIL reset_q: got %b expected 0", q);
    end
    checks++;
    if (q_bar !== 1'b1) begin
      errors++;
      $display("FAIL reset_q_bar: got %b expected 1", q_bar);
    end
  endtask

  task automatic test_toggle();
    logic exp_q;
    rst  = 1'b1;
    t_in = 1'b1;
    exp_q = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_q = ~exp_q;
      checks++;
      if (q !== exp_q) begin
        errors++;
        $display("FAIL toggle_q[%0d]: got %b expected %b", i, q, exp_q);
      end
      checks++;
      if (q_bar !== ~exp_q) begin
        errors++;
        $display("FAIL toggle_q_bar[%0d]: got %b expected %b", i, q_bar, ~exp_q);
      end
    end
  endtask

  task automatic test_hold();
    t_in = 1'b0;
    step();
    checks++;
    if (q !== 1'b0) begin
      errors++;
      $display("FAIL hold_q: got %b expected 0", q);
    end
    t_in = 1'b1;
    step();
    checks++;
    if (q !== 1'b1) begin
      errors++;
      $display("FAIL hold_then_toggle_q: got %b expected 1", q);
    end
  endtask

  task automatic test_reset_priority();
    rst  = 1'b0;
    t_in = 1'b1;
    step();
    checks++;
    if (q !== 1'b0) begin
      errors++;
      $display("FAIL rst_priority_q: got %b expected 0", q);
    end
    checks++;
    if (q_bar !== 1'b1) begin
      errors++;
      $display("FAIL rst_priority_q_bar: got %b expected 1", q_bar);
    end
  endtask

  task automatic test_resume();
    rst  = 1'b1;
    t_in = 1'b1;
    step();
    checks++;
    if (q !== 1'b1) begin
      errors++;
      $display("FAIL resume_q: got %b expected 1", q);
    end
  endtask

  task automatic test_glitch();
    t_in = 1'b0;
    #2 t_in = 1'b1;
    #2 t_in = 1'b0;
    #1 rst  = 1'b0;
    #1 rst  = 1'b1;
    checks++;
    if (q !== 1'b1) begin
      errors++;
      $display("FAIL glitch_between_edges_q: got %b expected 1", q);
    end
    step();
    checks++;
    if (q !== 1'b1) begin
      errors++;
      $display("FAIL glitch_next_edge_q: got %b expected 1", q);
    end
    checks++;
    if (q_bar !== 1'b0) begin
      errors++;
      $display("FAIL glitch_next_edge_q_bar: got %b expected 0", q_bar);
    end
  endtask

  task automatic test_vector();
    v_rst = 1'b0;
    v_t   = 4'b1111;
    step();
    checks++;
    if (v_q !== 4'b1010) begin
      errors++;
      $display("FAIL vec_reset_q: got %b expected 1010", v_q);
    end
    checks++;
    if (v_q_bar !== 4'b0101) begin
      errors++;
      $display("FAIL vec_reset_q_bar: got %b expected 0101", v_q_bar);
    end
    v_rst = 1'b1;
    v_t   = 4'b0110;
    step();
    checks++;
    if (v_q !== 4'b1100) begin
      errors++;
      $display("FAIL vec_toggle_q: got %b expected 1100", v_q);
    end
    checks++;
    if (v_q_bar !== 4'b0011) begin
      errors++;
      $display("FAIL vec_toggle_q_bar: got %b expected 0011", v_q_bar);
    end
    v_t = 4'b0001;
    step();
    checks++;
    if (v_q !== 4'b1101) begin
      errors++;
      $display("FAIL vec_single_bit_q: got %b expected 1101", v_q);
    end
    v_t = 4'b1000;
    step();
    checks++;
    if (v_q !== 4'b0101) begin
      errors++;
      $display("FAIL vec_msb_q: got %b expected 0101", v_q);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    t_in   = 1'b0;
    v_rst  = 1'b0;
    v_t    = 4'b0000;
    test_reset();
    test_toggle();
    test_hold();
    test_reset_priority();
    test_resume();
    test_glitch();
    test_vector();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
